// File: rtl/fft_32_input_framer_if.sv
// fft_32 input-side control struct and the framed output bus that carries it.
// Valid-only stream with no ready: a beat with Output_control.valid=1 must be consumed in that cycle.
package dsp_pkg;
  typedef struct packed {
    logic       valid;
    logic       last;
    logic       reverse;
    logic [4:0] data_index;
    logic [7:0] tag;
  } fft_control_t;
endpackage

interface fft_32_input_framer_if #(
  parameter int DATA_WIDTH = 16
);
  dsp_pkg::fft_control_t        Output_control;
  logic signed [DATA_WIDTH-1:0] Output_i;
  logic signed [DATA_WIDTH-1:0] Output_q;
  logic [0:0]                   Dbg_state;

  modport master (
    output Output_control,
    output Output_i,
    output Output_q,
    output Dbg_state
  );

  modport slave (
    input Output_control,
    input Output_i,
    input Output_q,
    input Dbg_state
  );
endinterface

// File: rtl/fft_32_input_framer.sv
// Ping-pong frame store: collects an unframed I/Q stream and emits only complete
// 32-sample frames to fft_32, tagging each one and counting dropped partial frames.
module fft_32_input_framer #(
  parameter int DATA_WIDTH  = 16,
  parameter int INITIAL_TAG = 0
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         Input_valid,
  input  logic                         Input_sof,
  input  logic signed [DATA_WIDTH-1:0] Input_i,
  input  logic signed [DATA_WIDTH-1:0] Input_q,
  input  logic                         Config_reverse,
  fft_32_input_framer_if.master        Output_bus,
  output logic [15:0]                  Drop_count
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // Write side
  logic [4:0]  wr_index;
  logic        wr_bank;
  logic [1:0]  bank_full;
  logic [1:0]  bank_rev;
  logic [7:0]  bank_tag [2];
  logic [7:0]  tag_cnt;
  logic [15:0] drop_cnt;

  // Read side
  logic [0:0]  state;
  logic        rd_bank;
  logic [4:0]  rd_index;

  logic [2*DATA_WIDTH-1:0] mem [64];
  logic [2*DATA_WIDTH-1:0] rd_data;

  logic       out_valid;
  logic       out_last;
  logic       out_rev;
  logic [4:0] out_index;
  logic [7:0] out_tag;

  logic       restart;
  logic [4:0] wr_addr_idx;
  logic       wr_done;
  logic       rd_en;
  logic       drain_done;

  always_comb begin
    // A start-of-frame in the middle of a frame throws the partial away and restarts at 0.
    restart     = Input_valid && Input_sof && (wr_index != 5'd0);
    wr_addr_idx = restart ? 5'd0 : wr_index;
    wr_done     = Input_valid && (wr_addr_idx == 5'd31);
    rd_en       = (state == ST_DRAIN);
    drain_done  = rd_en && (rd_index == 5'd31);
  end

  // Storage is not reset; out_valid masks stale read data.
  always_ff @(posedge Clk) begin
    if (Input_valid) begin
      mem[{wr_bank, wr_addr_idx}] <= {Input_i, Input_q};
    end
    rd_data <= mem[{rd_bank, rd_index}];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_index    <= 5'd0;
      wr_bank     <= 1'b0;
      bank_rev    <= 2'b00;
      bank_tag[0] <= 8'd0;
      bank_tag[1] <= 8'd0;
      tag_cnt     <= 8'(INITIAL_TAG);
      drop_cnt    <= 16'd0;
    end else if (Input_valid) begin
      wr_index <= wr_done ? 5'd0 : wr_addr_idx + 5'd1;
      if (wr_addr_idx == 5'd0) begin
        bank_rev[wr_bank] <= Config_reverse;
      end
      if (restart && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (wr_done) begin
        bank_tag[wr_bank] <= tag_cnt;
        tag_cnt           <= tag_cnt + 8'd1;
        wr_bank           <= ~wr_bank;
      end
    end
  end

  // The reader releases a bank on the same edge the writer may begin refilling it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bank_full <= 2'b00;
    end else begin
      if (drain_done) begin
        bank_full[rd_bank] <= 1'b0;
      end
      if (wr_done) begin
        bank_full[wr_bank] <= 1'b1;
      end
    end
  end

  // Banks fill alternately, so rd_bank toggling after each drain always points at the oldest.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= ST_IDLE;
      rd_bank  <= 1'b0;
      rd_index <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          rd_index <= 5'd0;
          if (bank_full[rd_bank]) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          rd_index <= rd_index + 5'd1;
          if (rd_index == 5'd31) begin
            rd_bank <= ~rd_bank;
            if (!bank_full[~rd_bank]) begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          rd_index <= 5'd0;
        end
      endcase
    end
  end

  // Control fields travel with the registered read so they line up with rd_data.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_rev   <= 1'b0;
      out_index <= 5'd0;
      out_tag   <= 8'd0;
    end else begin
      out_valid <= rd_en;
      out_last  <= drain_done;
      out_rev   <= rd_en & bank_rev[rd_bank];
      out_index <= rd_en ? rd_index : 5'd0;
      out_tag   <= rd_en ? bank_tag[rd_bank] : 8'd0;
    end
  end

  assign Output_bus.Output_control.valid      = out_valid;
  assign Output_bus.Output_control.last       = out_last;
  assign Output_bus.Output_control.reverse    = out_rev;
  assign Output_bus.Output_control.data_index = out_index;
  assign Output_bus.Output_control.tag        = out_tag;
  assign Output_bus.Output_i  = out_valid ? rd_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign Output_bus.Output_q  = out_valid ? rd_data[DATA_WIDTH-1:0] : '0;
  assign Output_bus.Dbg_state = state;
  assign Drop_count           = drop_cnt;

endmodule

// File: tb/tb_fft_32_input_framer.sv
// Bench for fft_32_input_framer: queue-based frame model, table of stream scenarios,
// and hand-written sequences for latency, contiguity, tag wrap and reset mid-drain.
module tb_fft_32_input_framer;
  localparam int DW       = 16;
  localparam int INIT_TAG = 0;
  localparam int EW       = 15 + 2 * DW;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_sof;
  logic                 in_rev;
  logic signed [DW-1:0] in_i;
  logic signed [DW-1:0] in_q;
  logic [15:0]          drop_count;

  fft_32_input_framer_if #(.DATA_WIDTH(DW)) out_if ();

  fft_32_input_framer #(.DATA_WIDTH(DW), .INITIAL_TAG(INIT_TAG)) dut (
    .Clk            (clk),
    .Rst_n          (rst_n),
    .Input_valid    (in_valid),
    .Input_sof      (in_sof),
    .Input_i        (in_i),
    .Input_q        (in_q),
    .Config_reverse (in_rev),
    .Output_bus     (out_if),
    .Drop_count     (drop_count)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_act;
  logic [EW-1:0] mon_exp;
  int errors = 0;
  int checks = 0;
  int beats = 0;
  int run = 0;
  int max_run = 0;
  int first_cyc = -1;
  int first_tag = -1;
  int last_tag = -1;
  int last_in_cyc = 0;

  // Reference model: collects accepted samples into a frame and queues 32 beats when complete
  logic signed [DW-1:0] part_i [32];
  logic signed [DW-1:0] part_q [32];
  int        part_len = 0;
  logic      part_rev = 1'b0;
  logic [7:0] tag_m = 8'(INIT_TAG);
  int        drop_m = 0;

  task automatic model_reset();
    exp_q.delete();
    part_len = 0;
    tag_m    = 8'(INIT_TAG);
    drop_m   = 0;
  endtask

  task automatic model_accept(logic signed [DW-1:0] i, logic signed [DW-1:0] q, logic sof, logic rev);
    if (sof && part_len != 0) begin
      if (drop_m < 65535) drop_m++;
      part_len = 0;
    end
    if (part_len == 0) part_rev = rev;
    part_i[part_len] = i;
    part_q[part_len] = q;
    part_len++;
    if (part_len == 32) begin
      for (int k = 0; k < 32; k++)
        exp_q.push_back({5'(k), (k == 31), part_rev, tag_m, part_i[k], part_q[k]});
      tag_m    = tag_m + 8'd1;
      part_len = 0;
    end
  endtask

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      mon_act = {out_if.Output_control.data_index, out_if.Output_control.last,
                 out_if.Output_control.reverse, out_if.Output_control.tag,
                 out_if.Output_i, out_if.Output_q};
      checks++;
      if (out_if.Output_control.valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected actual=%h required=none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL beat actual=%h required=%h", mon_act, mon_exp);
          end
        end
        beats++;
        run++;
        if (run > max_run) max_run = run;
        if (first_cyc < 0) begin
          first_cyc = cyc;
          first_tag = int'(out_if.Output_control.tag);
        end
        last_tag = int'(out_if.Output_control.tag);
      end else begin
        run = 0;
        if (mon_act !== '0) begin
          errors++;
          $display("FAIL idle_zero actual=%h required=0", mon_act);
        end
      end
    end
  end

  // A write must never land in a bank that is still waiting to drain
  always @(negedge clk) begin
    if (rst_n && in_valid) begin
      checks++;
      if (dut.bank_full[dut.wr_bank] && !(dut.drain_done && dut.rd_bank == dut.wr_bank)) begin
        errors++;
        $display("FAIL write_into_full actual=bank%0d_full required=empty", dut.wr_bank);
      end
    end
  end

  // Driver tasks
  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic signed [DW-1:0] i, logic signed [DW-1:0] q, logic sof, logic rev);
    in_valid = 1'b1;
    in_i     = i;
    in_q     = q;
    in_sof   = sof;
    in_rev   = rev;
    model_accept(i, q, sof, rev);
    @(posedge clk);
    #1;
    last_in_cyc = cyc;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(int n, int gap_max, int rev_mode, logic sof_first);
    logic rev;
    for (int k = 0; k < n; k++) begin
      if (gap_max > 0) idle($urandom_range(gap_max, 0));
      rev = (rev_mode == 2) ? 1'($urandom_range(1, 0)) : 1'(rev_mode);
      send(DW'($urandom), DW'($urandom), sof_first && (k == 0), rev);
    end
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_if.Output_control.valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    idle(4);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_rev   = 1'b0;
    in_i     = '0;
    in_q     = '0;
    model_reset();
    idle(2);
    chk("rst_control", out_if.Output_control, 0);
    chk("rst_data", {out_if.Output_i, out_if.Output_q}, 0);
    chk("rst_drop", drop_count, 0);
    rst_n = 1'b1;
    idle(1);
  endtask

  typedef struct {
    int n_pre;
    int n_frames;
    int gap_max;
    int rev_mode;
    int exp_drop;
    int exp_beats;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d0;
    int b0;
    int n;

    vecs[0] = '{n_pre: 0,  n_frames: 1,  gap_max: 0, rev_mode: 1, exp_drop: 0, exp_beats: 32};
    vecs[1] = '{n_pre: 0,  n_frames: 4,  gap_max: 0, rev_mode: 0, exp_drop: 0, exp_beats: 128};
    vecs[2] = '{n_pre: 10, n_frames: 1,  gap_max: 0, rev_mode: 0, exp_drop: 1, exp_beats: 32};
    vecs[3] = '{n_pre: 0,  n_frames: 2,  gap_max: 1, rev_mode: 2, exp_drop: 0, exp_beats: 64};
    vecs[4] = '{n_pre: 0,  n_frames: 20, gap_max: 5, rev_mode: 2, exp_drop: 0, exp_beats: 640};
    vecs[5] = '{n_pre: 5,  n_frames: 3,  gap_max: 2, rev_mode: 1, exp_drop: 1, exp_beats: 96};

    rst_n = 1'b0;

    // Single ramp frame: latency, ordering, tag
    do_reset();
    first_cyc = -1;
    b0 = beats;
    for (int k = 0; k < 32; k++) send(DW'(k), -DW'(k), k == 0, 1'b0);
    wait_drain(200);
    chk("t1_latency", first_cyc, last_in_cyc + 2);
    chk("t1_beats", beats - b0, 32);
    chk("t1_tag", first_tag, INIT_TAG);

    // Four frames back-to-back must come out as one unbroken run
    do_reset();
    max_run = 0;
    for (int f = 0; f < 4; f++) send_frame(32, 0, 0, 1'b1);
    wait_drain(300);
    chk("t2_run", max_run, 128);
    chk("t2_last_tag", last_tag, (INIT_TAG + 3) % 256);

    // Partial frame dropped by a new start-of-frame; no tag consumed
    do_reset();
    first_cyc = -1;
    b0 = beats;
    send_frame(10, 0, 0, 1'b1);
    send_frame(32, 0, 0, 1'b1);
    wait_drain(200);
    chk("t3_drop", drop_count, 1);
    chk("t3_beats", beats - b0, 32);
    chk("t3_tag", first_tag, INIT_TAG);

    // Scenario table
    do_reset();
    for (int v = 0; v < 6; v++) begin
      d0 = int'(drop_count);
      b0 = beats;
      if (vecs[v].n_pre > 0) send_frame(vecs[v].n_pre, vecs[v].gap_max, vecs[v].rev_mode, 1'b1);
      for (int f = 0; f < vecs[v].n_frames; f++)
        send_frame(32, vecs[v].gap_max, vecs[v].rev_mode, 1'b1);
      wait_drain(600);
      chk($sformatf("vec%0d_drop", v), int'(drop_count) - d0, vecs[v].exp_drop);
      chk($sformatf("vec%0d_beats", v), beats - b0, vecs[v].exp_beats);
      chk($sformatf("vec%0d_drop_model", v), drop_count, drop_m);
    end

    // Tag wrap over 257 frames
    do_reset();
    for (int f = 0; f < 257; f++) send_frame(32, 0, 0, 1'b1);
    wait_drain(300);
    chk("t_wrap_tag", last_tag, (INIT_TAG + 256) % 256);

    // Reset asserted at index 17 of a drain
    do_reset();
    send_frame(32, 0, 1, 1'b1);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      #1;
      if (out_if.Output_control.valid && out_if.Output_control.data_index == 5'd17) break;
      n++;
    end
    chk("t_rst_reach17", (n < 200), 1);
    rst_n = 1'b0;
    #1;
    chk("t_rst_control", out_if.Output_control, 0);
    chk("t_rst_data", {out_if.Output_i, out_if.Output_q}, 0);
    chk("t_rst_drop", drop_count, 0);
    model_reset();
    idle(3);
    rst_n = 1'b1;
    b0 = beats;
    idle(40);
    chk("t_rst_no_beats", beats - b0, 0);
    first_cyc = -1;
    send_frame(32, 0, 0, 1'b1);
    wait_drain(200);
    chk("t_rst_beats", beats - b0, 32);
    chk("t_rst_tag", first_tag, INIT_TAG);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fft_32_input_framer.md
Name: fft_32_input_framer

Overview:
Transmit-side source for the fft_32 input interface. It takes an unframed I/Q sample stream with an optional start-of-frame marker and buffers it in a ping-pong frame store. It emits only complete 32-sample frames on the fft_control_t interface, with data_index, last, reverse and tag fully populated. It sits directly in front of fft_32 and drives its Input_control, Input_i and Input_q ports.

Parameters:
DATA_WIDTH, 16, signed width of I and Q samples on both input and output.
INITIAL_TAG, 0, tag value assigned to the first complete frame after reset.

Ports:
Clk  in  1  clock.
Rst_n  in  1  asynchronous active-low reset.
Input_valid  in  1  sample strobe; at most one sample per cycle.
Input_sof  in  1  start-of-frame marker; qualified by Input_valid.
Input_i  in  DATA_WIDTH  signed I sample.
Input_q  in  DATA_WIDTH  signed Q sample.
Config_reverse  in  1  reverse flag; sampled per frame.
Output_control  out  fft_control_t  valid/last/reverse/data_index/tag (dsp_pkg); data_index 5 bits, tag 8 bits.
Output_i  out  DATA_WIDTH  I sample.
Output_q  out  DATA_WIDTH  Q sample.
Drop_count  out  16  saturating count of discarded partial frames.

Behaviour:
Reset:
- Reset is asynchronous and active-low.
- While Rst_n=0: Output_control all fields 0, Output_i=Output_q=0, Drop_count=0, wr_index=0, wr_bank=0, both banks empty, read FSM in IDLE, tag counter=INITIAL_TAG.
- Reset mid-frame discards all buffered and in-flight data. No output follows the release of reset until a new frame completes.

Write side:
- Two 32-entry banks, each entry {I,Q}, plus a per-bank full flag, reverse bit and tag.
- A sample is accepted when Input_valid=1 and is written to bank[wr_bank][wr_index].
- Config_reverse is latched into the bank's reverse bit at the index-0 write.
- Input_sof=1 with Input_valid=1 and wr_index!=0: the partial frame is discarded and Drop_count increments, saturating at 65535. The sample is written at index 0 and wr_index becomes 1. Input_sof with wr_index=0 is normal.
- Input_sof with Input_valid=0 is ignored.
- Write at wr_index=31:
  - bank marked full;
  - bank tag = tag counter, then the counter increments, wrapping 255->0;
  - wr_bank toggles and wr_index becomes 0.
- Dropped frames do not consume a tag.
- Writing into a bank still marked full cannot occur at one sample per cycle. The bench asserts on it.

Read FSM (IDLE, DRAIN):
- IDLE -> DRAIN when the oldest full bank exists. Banks drain in completion order.
- DRAIN issues reads at index 0..31 on consecutive cycles. Memory read is registered, so outputs appear 1 cycle after each read.
- A frame whose last write is at cycle N has index 0 valid at cycle N+2 at the earliest. The 32 outputs are back-to-back.
- On the read of index 31 the bank's full flag clears.
- At the end of a drain: if the other bank is full, DRAIN continues with it with no gap cycle (index 31 of frame k is followed immediately by index 0 of frame k+1); otherwise the FSM returns to IDLE.
- Per output beat:
  - valid=1;
  - data_index = read index;
  - last=1 only at index 31;
  - reverse and tag taken from the bank.
- Non-valid cycles: valid=0; all other control fields and data driven 0.
- Simultaneous events: a frame completing on the same cycle its bank partner finishes draining is handled without stall or loss.

Test Plan:
- 32 samples, Input_i=k, Input_q=-k, Input_sof on the first, Config_reverse=0 -> one frame: data_index 0..31, I=k, last only at 31, reverse=0, tag=INITIAL_TAG, first valid 2 cycles after the last input.
- 4 frames back-to-back at one sample per cycle -> 128 contiguous valid beats with no gaps; tags 0,1,2,3; no sample loss.
- 10 samples, then Input_sof with 32 new samples -> Drop_count=1; exactly one frame containing only the new samples; tag=INITIAL_TAG (no tag consumed by the drop).
- Config_reverse toggled mid-frame -> the frame carries the value sampled at index 0. Tag wrap: 257 frames -> the 257th has tag 0.
- Random 0-5 cycle input gaps across 20 frames, checked against a reference model -> all data and index fields match.
- Rst_n asserted at index 17 of a drain -> outputs 0 immediately (asynchronous); no further beats; Drop_count=0. After release, the next full frame is emitted normally with tag=INITIAL_TAG.
